// File: rtl/pulse_div_ctrl_if.sv
// Configuration handshake for pulse_div_ctrl.
// Host drives the offer, controller answers with cfg_ready.
interface pulse_div_ctrl_if #(
  parameter int N = 24
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_div;
  logic [1:0]   cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/pulse_div_ctrl.sv
// Programmable pulse divider controller.
// Sequences a prescaler through start/pause/stop and counts ticks.
module pulse_div_ctrl #(
  parameter int N = 24
) (
  input  logic             clk,
  input  logic             reset,
  pulse_div_ctrl_if.slave  cfg,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [3:0]       q
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] div_q, div_d;
  logic [1:0]   mode_q, mode_d;
  logic [3:0]   q_q, q_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         idle;
  logic         acc;
  logic [N-1:0] last;

  assign idle = (state_q == IDLE);
  assign acc  = cfg.cfg_valid & idle;
  // A zero ratio behaves as divide-by-one.
  assign last = (div_q == '0) ? '0 : div_q - N'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mode_d  = mode_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          div_d  = cfg.cfg_div;
          mode_d = cfg.cfg_mode;
        end
        if (start &&
            (mode_d == 2'b01 || mode_d == 2'b10)) begin
          state_d = RUN;
          cnt_d   = '0;
          q_d     = '0;
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
          if (cnt_q == last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            q_d    = q_q + 4'd1;
            if (mode_q == 2'b10) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + N'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= N'(1);
      mode_q  <= 2'b00;
      q_q     <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign cfg.cfg_ready = idle;
  assign busy          = ~idle;
  assign tick          = tick_q;
  assign done          = done_q;
  assign q             = q_q;

endmodule
